pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised handshaked pipeline-stage register for the 5-stage CPU datapath, successor to the plain enable/clear stage flop. Carries a WIDTH-bit payload between stages with valid/ready flow control, synchronous flush, an optional skid buffer that registers the backward ready path, and a saturating stall-cycle counter for performance analysis. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- WIDTH, 32, payload width in bits (≥1)
- CNT_W, 16, stall counter width in bits (≥1)

- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of all held entries (branch/exception squash)
- in_valid  in  1  upstream has payload
- in_ready  out  1  stage accepts payload this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  stage presents payload
- out_ready  in  1  downstream accepts payload
- out_data  out  WIDTH  presented payload
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Storage: main register (out_valid/out_data) and skid register (skid_valid/skid_data, present only with macro).
- States: EMPTY (main empty), FULL (main valid, skid empty), SKID (both valid).
- EMPTY: in_valid → load main, go FULL; else stay.
- FULL: in_valid & out_ready → main<=in_data, stay FULL; in_valid & ~out_ready → skid<=in_data, go SKID (macro) / not possible (no macro, in_ready=0); ~in_valid & out_ready → EMPTY; else hold.
- SKID: in_ready=0; out_ready → main<=skid_data, skid emptied, go FULL; else hold.
- Payload order strictly preserved; no payload dropped or duplicated except by flush.
- flush: next cycle state EMPTY, out_valid=0, skid_valid=0, out_data=0, skid_data=0; a payload offered in the same cycle as flush is discarded even if in_ready=1. flush has no effect on stall_cnt.
- rst: priority over flush; all valids 0, data 0, stall_cnt 0, state EMPTY.
- stall_cnt: +1 each cycle out_valid & ~out_ready (evaluated on pre-edge values); holds at 2^CNT_W−1; cleared only by rst.
- Data registers load only on accepted transfer; held otherwise (no X propagation when idle).

## Timing
- Latency: payload accepted at edge N appears on out_data with out_valid=1 after edge N (1 cycle).
- Throughput: one payload per cycle when out_ready held high.
- Reset values: out_valid=0, out_data=0, in_ready=1 (macro) / 1 (no macro, since out_valid=0), stall_cnt=0.
- With macro, in_ready is a direct register output (= ~skid_valid); no combinational path out_ready→in_ready.
- Without macro, in_ready = ~out_valid | out_ready (combinational).
- out_valid, out_data always registered; no in→out combinational path.

## Configuration
- PIPE_STAGE_SKID_EN defined: skid register and SKID state compiled in; in_ready registered; upstream may see one extra accepted payload after out_ready drops.
- Undefined: skid logic removed, states EMPTY/FULL only, in_ready combinational as above; functionally identical payload sequence, different in_ready timing.

## Structure
- Shared package pipe_pkg: state encoding localparams (PS_EMPTY=2'd0, PS_FULL=2'd1, PS_SKID=2'd2), default WIDTH/CNT_W constants.
- One sub-module: sat_counter (parameter W; inc, rst; saturating count) used for stall_cnt.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1, in_data=32'hDEADBEEF → out_valid=0, out_data=0, stall_cnt=0, in_ready=1 after release.
- Streaming: out_ready=1, feed 0x1..0x8 back-to-back → out_data 0x1..0x8 on consecutive cycles, each 1 cycle after acceptance, stall_cnt=0.
- Backpressure (macro on): stream 0x10,0x11,0x12, drop out_ready after 0x10 presented → 0x11 lands in skid, in_ready=0 next cycle, 0x12 held upstream; raise out_ready → 0x10,0x11,0x12 in order, none lost.
- Backpressure (macro off): same stimulus → in_ready falls same cycle as out_ready, order 0x10,0x11,0x12 preserved.
- Flush in SKID state with in_valid=1, in_data=0x99 → next cycle out_valid=0, skid empty, 0x99 never appears at output; stall_cnt unchanged.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles → stall_cnt reaches 15 and holds; flush does not clear, rst does.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Purpose : shared constants for the handshaked pipeline-stage register.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: stage state encoding and default payload / stall-counter widths.
package pipe_pkg;

  // Stage occupancy encoding
  localparam logic [1:0] PS_EMPTY = 2'd0;  // main register empty
  localparam logic [1:0] PS_FULL  = 2'd1;  // main valid, skid empty
  localparam logic [1:0] PS_SKID  = 2'd2;  // main and skid both valid

  localparam int unsigned PIPE_WIDTH_DEF = 32;
  localparam int unsigned PIPE_CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Purpose : saturating up-counter, sticks at all-ones until reset.
// Latency : count updates on the edge after inc is sampled high.
// Backpressure: none; inc is a plain per-cycle strobe.
//
// Ports: clk, rst (sync, active-high), inc (count strobe), count (W bits).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Purpose : valid/ready pipeline-stage register with flush and stall counter.
// Latency : 1 cycle in->out; one payload per cycle while out_ready is high.
// Backpressure: with PIPE_STAGE_SKID_EN a skid entry absorbs one payload and
//   in_ready is a register; without it in_ready = ~out_valid | out_ready.
//
// Ports: clk, rst (sync, active-high), flush (sync squash of held entries),
//   in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
//   (downstream), stall_cnt (saturating count of out_valid & ~out_ready).
// Build option: define PIPE_STAGE_SKID_EN to compile in the skid register.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEF,
  parameter int CNT_W = PIPE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [1:0] state;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  // rst and flush clear the same storage; the stall counter sits outside
  // this block so flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state      <= PS_EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (in_valid) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= PS_FULL;
          end
        end
        PS_FULL: begin
          if (out_ready) begin
            if (in_valid) begin
              out_data <= in_data;
            end else begin
              out_valid <= 1'b0;
              state     <= PS_EMPTY;
            end
          end else if (in_valid) begin
            // in_ready was already high this cycle, so the payload must be
            // caught here rather than refused.
            skid_data  <= in_data;
            skid_valid <= 1'b1;
            state      <= PS_SKID;
          end
        end
        PS_SKID: begin
          if (out_ready) begin
            out_data   <= skid_data;
            skid_valid <= 1'b0;
            state      <= PS_FULL;
          end
        end
        default: begin
          state      <= PS_EMPTY;
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  // Straight from a flop: breaks the out_ready -> in_ready timing path.
  assign in_ready = ~skid_valid;

`else
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= PS_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (in_valid) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= PS_FULL;
          end
        end
        PS_FULL: begin
          // Without out_ready, in_ready is low, so in_valid is ignored.
          if (out_ready) begin
            if (in_valid) begin
              out_data <= in_data;
            end else begin
              out_valid <= 1'b0;
              state     <= PS_EMPTY;
            end
          end
        end
        default: begin
          state     <= PS_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = ~out_valid | out_ready;
`endif

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; works with or without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  stall_cnt;

  int tests_run = 0;
  int fails = 0;

  logic [31:0] send_q[$];
  logic [31:0] log_q[$];
  logic        rdy_seen;

  pipe_stage_reg #(.WIDTH(32), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Record every downstream transfer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) log_q.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: offer head of send_q, pop it if it was accepted.
  task automatic cycle(input logic ordy);
    logic acc;
    out_ready = ordy;
    if (send_q.size() > 0) begin
      in_valid = 1'b1;
      in_data  = send_q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = '0;
    end
    #1;
    rdy_seen = in_ready;
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    if (acc) send_q.delete(0);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    send_q.delete();
    log_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
    tests_run++;
    if (stall_cnt !== 4'd0) begin fails++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    in_valid = 1'b0; in_data = '0;
    tick();
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      send_q.delete();
      send_q.push_back(32'(i));
      cycle(1'b1);
      tests_run++;
      if (rdy_seen !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, rdy_seen); end
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        fails++; $display("FAIL stream_out[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, i);
      end
    end
    cycle(1'b1);
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain got v=%b want 0", out_valid); end
    tests_run++;
    if (log_q.size() != 8) begin fails++; $display("FAIL stream_count got %0d want 8", log_q.size()); end
    tests_run++;
    if (stall_cnt !== 4'd0) begin fails++; $display("FAIL stream_stall got %0d want 0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    send_q = '{32'h10, 32'h11, 32'h12};
    cycle(1'b1);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'h10) begin
      fails++; $display("FAIL bp_first got v=%b d=%h want v=1 d=10", out_valid, out_data);
    end
    cycle(1'b0);
    tests_run++;
    if (rdy_seen !== SKID) begin fails++; $display("FAIL bp_in_ready_drop got %b want %b", rdy_seen, SKID); end
    tests_run++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_next got %b want 0", in_ready); end
    cycle(1'b0);
    tests_run++;
    if (out_data !== 32'h10 || send_q.size() != (SKID ? 1 : 2)) begin
      fails++; $display("FAIL bp_hold got d=%h pending=%0d want d=10 pending=%0d",
                        out_data, send_q.size(), SKID ? 1 : 2);
    end
    n = 0;
    while ((send_q.size() > 0 || out_valid) && n < 12) begin
      cycle(1'b1);
      n++;
    end
    tests_run++;
    if (n >= 12) begin fails++; $display("FAIL bp_timeout got %0d cycles want <12", n); end
    tests_run++;
    if (log_q.size() != 3 || log_q[0] !== 32'h10 || log_q[1] !== 32'h11 || log_q[2] !== 32'h12) begin
      fails++; $display("FAIL bp_order got %0d items want 10,11,12", log_q.size());
    end
    tests_run++;
    if (stall_cnt !== 4'd2) begin fails++; $display("FAIL bp_stall got %0d want 2", stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    send_q = '{32'h20, 32'h21};
    cycle(1'b1);
    cycle(1'b0);
    send_q.delete();
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== !SKID) begin fails++; $display("FAIL flush_in_ready got %b want %b", in_ready, !SKID); end
    tick();
    flush = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      fails++; $display("FAIL flush_clear got v=%b d=%h want v=0 d=0", out_valid, out_data);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_skid_empty got in_ready=%b want 1", in_ready); end
    tests_run++;
    if (stall_cnt !== 4'd1) begin fails++; $display("FAIL flush_stall got %0d want 1", stall_cnt); end
    for (int i = 0; i < 4; i++) cycle(1'b1);
    tests_run++;
    if (log_q.size() != 1 || log_q[0] !== 32'h20 || out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_no_99 got %0d items v=%b want 1 item (20) v=0", log_q.size(), out_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    send_q = '{32'h30};
    cycle(1'b1);
    out_ready = 1'b0; in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) begin
        tests_run++;
        if (stall_cnt !== 4'd14) begin fails++; $display("FAIL sat_mid got %0d want 14", stall_cnt); end
      end
    end
    tests_run++;
    if (stall_cnt !== 4'd15 || out_data !== 32'h30) begin
      fails++; $display("FAIL sat_hold got cnt=%0d d=%h want cnt=15 d=30", stall_cnt, out_data);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tests_run++;
    if (stall_cnt !== 4'd15 || out_valid !== 1'b0) begin
      fails++; $display("FAIL sat_flush got cnt=%0d v=%b want cnt=15 v=0", stall_cnt, out_valid);
    end
    do_reset();
    tests_run++;
    if (stall_cnt !== 4'd0) begin fails++; $display("FAIL sat_rst got %0d want 0", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
